// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
//   master : decode/write-back side; drives indices, write data, reserve.
//   slave  : the register file; returns read data, busy flags, any_busy.
// All signals are level-sampled every cycle; there is no valid/ready
// handshake because the register file accepts every port every cycle.
interface regfile_mp_if #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 2,
   parameter int WR_PORTS = 1
) ();
   logic [RD_PORTS*ADDR_W-1:0] rd_reg;
   logic [RD_PORTS*DATA_W-1:0] rd_data;
   logic [RD_PORTS-1:0]        rd_busy;
   logic [WR_PORTS-1:0]        wr_en;
   logic [WR_PORTS*ADDR_W-1:0] wr_reg;
   logic [WR_PORTS*DATA_W-1:0] wr_data;
   logic                       rsv_en;
   logic [ADDR_W-1:0]          rsv_reg;
   logic                       any_busy;

   modport master (
      output rd_reg, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  rd_reg, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
      output rd_data, rd_busy, any_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register
// busy scoreboard, optional hardwired zero register and optional
// same-cycle write-to-read bypass.
// Ports:
//   clk  - single clock, all state updates on posedge
//   rst  - synchronous active-high reset; clears data and busy bits
//   bus  - regfile_mp_if.slave: read indices/data/busy, write ports,
//          reserve request and any_busy summary
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 2,
   parameter int WR_PORTS = 1,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic          clk,
   input logic          rst,
   regfile_mp_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   // Read-path scratch, one slot per read port.
   logic [ADDR_W-1:0] rd_idx  [RD_PORTS];
   logic [DATA_W-1:0] rd_val  [RD_PORTS];
   logic              rd_bsy  [RD_PORTS];

   // Next-state: writes in ascending port order so the highest port wins
   // on a shared index; the reserve is applied last so a new producer
   // supersedes the write that releases the old one.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int w = 0; w < WR_PORTS; w++) begin
         if (bus.wr_en[w]) begin
            mem_d[bus.wr_reg[w*ADDR_W +: ADDR_W]]  = bus.wr_data[w*DATA_W +: DATA_W];
            busy_d[bus.wr_reg[w*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (bus.rsv_en) begin
         busy_d[bus.rsv_reg] = 1'b1;
      end
      // Register 0 drops both writes and reservations.
      if (ZERO_REG) begin
         mem_d[0]  = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read. Bypass scans write ports in ascending order so the
   // highest matching port supplies the data; a bypassed read is busy only
   // if the same index is being reserved this cycle.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         rd_idx[p] = bus.rd_reg[p*ADDR_W +: ADDR_W];
         rd_val[p] = mem_q[rd_idx[p]];
         rd_bsy[p] = busy_q[rd_idx[p]];
         if (BYPASS) begin
            for (int w = 0; w < WR_PORTS; w++) begin
               if (bus.wr_en[w] && (bus.wr_reg[w*ADDR_W +: ADDR_W] == rd_idx[p])) begin
                  rd_val[p] = bus.wr_data[w*DATA_W +: DATA_W];
                  rd_bsy[p] = bus.rsv_en && (bus.rsv_reg == rd_idx[p]);
               end
            end
         end
         if (ZERO_REG && (rd_idx[p] == '0)) begin
            rd_val[p] = '0;
            rd_bsy[p] = 1'b0;
         end
         bus.rd_data[p*DATA_W +: DATA_W] = rd_val[p];
         bus.rd_busy[p]                  = rd_bsy[p];
      end
   end

   // Registered view only; deliberately not bypassed.
   assign bus.any_busy = |busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share the
// stimulus: dut_a has bypass and two write ports, dut_b has no bypass and
// one write port. Reads are checked against hand-derived values.
module tb_regfile_mp;
   logic clk;
   logic rst;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .WR_PORTS(2)) if_a ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .WR_PORTS(1)) if_b ();

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .WR_PORTS(2),
                .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .WR_PORTS(1),
                .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_idle();
      if_a.wr_en  = '0;
      if_a.rsv_en = 1'b0;
      if_b.wr_en  = '0;
      if_b.rsv_en = 1'b0;
   endtask

   task automatic drive_wr(input logic [4:0] r, input logic [31:0] d);
      if_a.wr_en   = 2'b01;
      if_a.wr_reg  = {5'd0, r};
      if_a.wr_data = {32'd0, d};
      if_b.wr_en   = 1'b1;
      if_b.wr_reg  = r;
      if_b.wr_data = d;
   endtask

   task automatic drive_rsv(input logic [4:0] r);
      if_a.rsv_en  = 1'b1;
      if_a.rsv_reg = r;
      if_b.rsv_en  = 1'b1;
      if_b.rsv_reg = r;
   endtask

   task automatic drive_rd(input logic [4:0] r0, input logic [4:0] r1);
      if_a.rd_reg = {r1, r0};
      if_b.rd_reg = {r1, r0};
   endtask

   // Advance past the next active edge; inputs change 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle well before the next edge.
   task automatic settle();
      #1;
   endtask

   // ---------------- read sweep table ----------------
   typedef struct {
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
   } rd_vec_t;

   rd_vec_t vecs[32];

   initial begin
      // Register i holds i+0x100 after the sweep, register 0 stays 0.
      for (int i = 0; i < 32; i++) begin
         vecs[i].r0 = 5'(i);
         vecs[i].r1 = 5'(31 - i);
         vecs[i].e0 = (i == 0)  ? 32'd0 : 32'(i + 32'h100);
         vecs[i].e1 = (i == 31) ? 32'd0 : 32'(31 - i + 32'h100);
      end

      rst = 1'b1;
      if_a.wr_reg = '0; if_a.wr_data = '0; if_a.rsv_reg = '0;
      if_b.wr_reg = '0; if_b.wr_data = '0; if_b.rsv_reg = '0;
      drive_idle();
      drive_rd(5'd0, 5'd0);
      tick();
      tick();
      rst = 1'b0;
      settle();

      // ---- reset state ----
      drive_rd(5'd5, 5'd9);
      settle();
      check("rst_a_d0",   if_a.rd_data[31:0],  32'd0);
      check("rst_a_d1",   if_a.rd_data[63:32], 32'd0);
      check("rst_a_busy", 32'(if_a.rd_busy),   32'd0);
      check("rst_a_any",  32'(if_a.any_busy),  32'd0);
      check("rst_b_any",  32'(if_b.any_busy),  32'd0);

      // ---- reset clear: preload reg 5 busy with DEADBEEF ----
      drive_wr(5'd5, 32'hDEADBEEF);
      drive_rsv(5'd5);
      drive_rd(5'd5, 5'd5);
      tick();
      drive_idle();
      settle();
      check("pre_a_d0",   if_a.rd_data[31:0],  32'hDEADBEEF);
      check("pre_a_busy", 32'(if_a.rd_busy[0]), 32'd1);
      check("pre_a_any",  32'(if_a.any_busy),  32'd1);
      check("pre_b_d1",   if_b.rd_data[63:32], 32'hDEADBEEF);
      // Reset asserted together with a write/reserve that must be discarded.
      rst = 1'b1;
      drive_wr(5'd6, 32'h66);
      drive_rsv(5'd6);
      settle();
      check("inrst_a_d0", if_a.rd_data[31:0], 32'hDEADBEEF);
      tick();
      rst = 1'b0;
      drive_idle();
      settle();
      check("clr_a_d0",   if_a.rd_data[31:0],  32'd0);
      check("clr_a_d1",   if_a.rd_data[63:32], 32'd0);
      check("clr_a_busy", 32'(if_a.rd_busy),   32'd0);
      check("clr_a_any",  32'(if_a.any_busy),  32'd0);
      check("clr_b_d0",   if_b.rd_data[31:0],  32'd0);
      check("clr_b_any",  32'(if_b.any_busy),  32'd0);
      drive_rd(5'd6, 5'd6);
      settle();
      check("clr_a_r6",      if_a.rd_data[31:0], 32'd0);
      check("clr_a_r6_busy", 32'(if_a.rd_busy),  32'd0);

      // ---- sweep writes ----
      for (int i = 1; i < 32; i++) begin
         drive_wr(5'(i), 32'(i + 32'h100));
         tick();
      end
      drive_wr(5'd0, 32'h55);
      drive_rd(5'd0, 5'd0);
      settle();
      check("r0_byp_a", if_a.rd_data[31:0], 32'd0);
      tick();
      drive_idle();
      settle();
      check("r0_a", if_a.rd_data[31:0], 32'd0);
      check("r0_b", if_b.rd_data[31:0], 32'd0);

      // ---- table-driven read sweep ----
      for (int k = 0; k < 32; k++) begin
         drive_rd(vecs[k].r0, vecs[k].r1);
         settle();
         check($sformatf("sw_a_d0[%0d]", k), if_a.rd_data[31:0],  vecs[k].e0);
         check($sformatf("sw_a_d1[%0d]", k), if_a.rd_data[63:32], vecs[k].e1);
         check($sformatf("sw_b_d0[%0d]", k), if_b.rd_data[31:0],  vecs[k].e0);
         check($sformatf("sw_b_d1[%0d]", k), if_b.rd_data[63:32], vecs[k].e1);
         check($sformatf("sw_a_bsy[%0d]", k), 32'(if_a.rd_busy),  32'd0);
      end

      // ---- bypass ----
      drive_rd(5'd7, 5'd7);
      drive_wr(5'd7, 32'h1234);
      settle();
      check("byp_a_pre", if_a.rd_data[63:32], 32'h1234);
      check("byp_b_pre", if_b.rd_data[63:32], 32'h107);
      tick();
      drive_idle();
      settle();
      check("byp_a_post", if_a.rd_data[63:32], 32'h1234);
      check("byp_b_post", if_b.rd_data[63:32], 32'h1234);

      // ---- scoreboard ----
      drive_rsv(5'd9);
      drive_rd(5'd9, 5'd9);
      settle();
      check("rsv_a_same", 32'(if_a.rd_busy[1]), 32'd0);
      tick();
      drive_idle();
      settle();
      check("rsv_a_busy", 32'(if_a.rd_busy[1]), 32'd1);
      check("rsv_a_any",  32'(if_a.any_busy),   32'd1);
      check("rsv_b_busy", 32'(if_b.rd_busy[1]), 32'd1);
      check("rsv_b_any",  32'(if_b.any_busy),   32'd1);
      drive_wr(5'd9, 32'hA);
      settle();
      check("rel_a_byp_busy", 32'(if_a.rd_busy[1]), 32'd0);
      check("rel_a_byp_d",    if_a.rd_data[63:32],  32'hA);
      check("rel_a_byp_any",  32'(if_a.any_busy),   32'd1);
      check("rel_b_pre_busy", 32'(if_b.rd_busy[1]), 32'd1);
      check("rel_b_pre_d",    if_b.rd_data[63:32],  32'h109);
      tick();
      drive_idle();
      settle();
      check("rel_a_busy", 32'(if_a.rd_busy[1]), 32'd0);
      check("rel_a_d",    if_a.rd_data[63:32],  32'hA);
      check("rel_a_any",  32'(if_a.any_busy),   32'd0);
      check("rel_b_busy", 32'(if_b.rd_busy[1]), 32'd0);
      check("rel_b_d",    if_b.rd_data[63:32],  32'hA);
      check("rel_b_any",  32'(if_b.any_busy),   32'd0);

      // ---- simultaneous write + reserve on reg 3 ----
      drive_wr(5'd3, 32'h77);
      drive_rsv(5'd3);
      drive_rd(5'd3, 5'd3);
      settle();
      check("wr_rsv_a_byp_d",    if_a.rd_data[31:0],  32'h77);
      check("wr_rsv_a_byp_busy", 32'(if_a.rd_busy[0]), 32'd1);
      tick();
      drive_idle();
      settle();
      check("wr_rsv_a_d",    if_a.rd_data[31:0],   32'h77);
      check("wr_rsv_a_busy", 32'(if_a.rd_busy[0]), 32'd1);
      check("wr_rsv_a_any",  32'(if_a.any_busy),   32'd1);
      check("wr_rsv_b_d",    if_b.rd_data[31:0],   32'h77);
      check("wr_rsv_b_busy", 32'(if_b.rd_busy[0]), 32'd1);
      drive_wr(5'd3, 32'h78);
      tick();
      drive_idle();

      // ---- reserve on reg 0 is dropped ----
      drive_rsv(5'd0);
      drive_rd(5'd0, 5'd0);
      tick();
      drive_idle();
      settle();
      check("rsv0_a_busy", 32'(if_a.rd_busy), 32'd0);
      check("rsv0_a_any",  32'(if_a.any_busy), 32'd0);
      check("rsv0_b_any",  32'(if_b.any_busy), 32'd0);

      // ---- double reserve, single release ----
      drive_rsv(5'd10);
      tick();
      drive_rsv(5'd10);
      tick();
      drive_idle();
      drive_wr(5'd10, 32'hBB);
      tick();
      drive_idle();
      drive_rd(5'd10, 5'd10);
      settle();
      check("dbl_a_busy", 32'(if_a.rd_busy), 32'd0);
      check("dbl_a_any",  32'(if_a.any_busy), 32'd0);
      check("dbl_b_d",    if_b.rd_data[31:0], 32'hBB);
      check("dbl_b_any",  32'(if_b.any_busy), 32'd0);

      // ---- write-port conflict on dut_a ----
      if_a.rsv_en  = 1'b1;
      if_a.rsv_reg = 5'd4;
      tick();
      drive_idle();
      if_a.wr_en   = 2'b11;
      if_a.wr_reg  = {5'd4, 5'd4};
      if_a.wr_data = {32'h22, 32'h11};
      drive_rd(5'd4, 5'd4);
      settle();
      check("cfl_a_byp_d",    if_a.rd_data[31:0],  32'h22);
      check("cfl_a_byp_busy", 32'(if_a.rd_busy[0]), 32'd0);
      tick();
      drive_idle();
      settle();
      check("cfl_a_d",    if_a.rd_data[31:0],   32'h22);
      check("cfl_a_busy", 32'(if_a.rd_busy[0]), 32'd0);
      check("cfl_a_any",  32'(if_a.any_busy),   32'd0);
      check("cfl_b_d",    if_b.rd_data[31:0],   32'h104);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath. It replaces the fixed two-read/one-write register file and adds:
- configurable read and write port counts;
- same-cycle write-to-read bypass;
- a hardwired zero register;
- a per-register busy scoreboard that the pipeline uses to detect pending writes and stall.

It sits between decode (read and reserve) and write-back (write and release).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2^ADDR_W
- RD_PORTS, 2, number of read ports (1..4)
- WR_PORTS, 1, number of write ports (1..2)
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and reservations
- BYPASS, 1, when 1, a same-cycle write is visible on read data and busy outputs

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high, sampled on posedge
- rd_reg  in  RD_PORTS*ADDR_W  read indices; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*DATA_W  read data, combinational from rd_reg
- rd_busy  out  RD_PORTS  1 = the indexed register has a pending write
- wr_en  in  WR_PORTS  per-port write enable
- wr_reg  in  WR_PORTS*ADDR_W  write indices
- wr_data  in  WR_PORTS*DATA_W  write data
- rsv_en  in  1  reserve a destination (set its busy bit)
- rsv_reg  in  ADDR_W  register to reserve
- any_busy  out  1  OR of all busy bits

## Operation
- Storage: 2^ADDR_W × DATA_W registers and 2^ADDR_W busy bits.
- Reset (rst=1 at posedge):
  - all registers become 0 and all busy bits become 0;
  - writes and reservations in the same cycle are discarded.
- Write: on posedge, for each port with wr_en=1, mem[wr_reg] <= wr_data and busy[wr_reg] <= 0.
  - Two ports writing the same index in one cycle: the higher port index wins for both data and busy.
- Reserve: on posedge with rsv_en=1, busy[rsv_reg] <= 1.
  - Reserve and write to the same index in one cycle: the data is written and busy ends at 1. The new producer supersedes the old.
- Read (combinational per port p):
  - If ZERO_REG and rd_reg=0: rd_data=0 and rd_busy=0.
  - Else if BYPASS and some wr_en[w] has wr_reg[w]=rd_reg: rd_data=wr_data of the highest such w, and rd_busy=0 (or 1 if rsv_en targets the same index this cycle).
  - Else: rd_data=mem[rd_reg] and rd_busy=busy[rd_reg].
- With BYPASS=0, reads show only the pre-clock state; a write becomes visible on the cycle after its posedge.
- Register 0 with ZERO_REG=1: writes are dropped, reservations are dropped, and busy[0] is constant 0.
- Writing a register whose busy bit is 0 is legal: data updates and busy stays 0.
- Reserving an already-busy register is legal: busy stays 1. There is no counting; one write releases it.
- any_busy reflects registered busy bits only and does not bypass.
- During rst=1, outputs still follow the combinational read rules on the pre-reset state. From the first cycle after the reset edge, every read returns 0 with rd_busy=0.

## Timing
- Read latency: 0 cycles (combinational).
- Write and reserve latency: 1 clock edge.
- With BYPASS=1, a write is observable in the same cycle it is presented; with BYPASS=0, in the next cycle.
- Reset value of all outputs after the reset edge: rd_data=0, rd_busy=0, any_busy=0.
- No handshake stalls inside the block. Port counts and reserve are accepted every cycle.

## Test plan
- Reset clear:
  - Preload mem[5]=0xDEADBEEF with busy[5]=1, then assert rst for 1 cycle.
  - Required after the reset edge: rd_data on both ports for reg 5 = 0, rd_busy=0, any_busy=0.
- Sweep:
  - Write reg i with value i+0x100 for i=1..31, one per cycle; then read all 32 on both ports.
  - Required: reg 0 reads 0 and reg i reads i+0x100. A write of 0x55 to reg 0 keeps reading 0.
- Bypass:
  - With BYPASS=1: wr_en=1, wr_reg=7, wr_data=0x1234, rd_reg port1=7 in the same cycle. Required: rd_data=0x1234 before the edge.
  - With BYPASS=0: the old value before the edge and 0x1234 after it.
- Scoreboard:
  - rsv_en on reg 9. Required next cycle: rd_busy=1 and any_busy=1.
  - Then write reg 9 = 0xA. Required after the edge: rd_busy=0, rd_data=0xA, any_busy=0.
- Simultaneous events:
  - Same cycle: write reg 3 = 0x77 and rsv_en on reg 3. Required after the edge: rd_data=0x77 and rd_busy=1.
  - Same cycle: rsv_en on reg 0. Required: busy stays 0.
- Write-port conflict (WR_PORTS=2):
  - Port0 writes reg 4 = 0x11 and port1 writes reg 4 = 0x22 in the same cycle.
  - Required: the bypassed read shows 0x22, and after the edge reg 4 = 0x22.
